boot_ram_loader: RTL and testbench

BOOT_RAM_LOADER -- requirements
Module: boot_ram_loader

---
 rtl/boot_ram_loader.sv | 162 ++++++++++++++++
 tb/tb_boot_ram_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_ram_loader.sv
// Loads a length-prefixed image from a byte stream into boot RAM, then releases the core from reset.
// Optional trailing checksum byte: define BOOT_LOADER_CKSUM_EN.
`ifndef XLEN
`define XLEN 32
`endif

module boot_ram_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [`XLEN-1:0]  ram_wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE,
`ifdef BOOT_LOADER_CKSUM_EN
    CKSUM,
`endif
    DONE, ERR
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      len_reg;
  logic [15:0]      len_rx;
  logic [`XLEN-1:0] word_reg, word_next;
  logic [1:0]       byte_idx_reg;
  logic [ADDR_W:0]  cnt_reg;
  logic [15:0]      cnt_ext;
  logic             accept;
  logic             last_word;
`ifdef BOOT_LOADER_CKSUM_EN
  logic [7:0]       sum_reg;
`endif

  assign accept    = rx_valid & rx_ready;
  assign len_rx    = {rx_data, len_reg[7:0]};
  assign cnt_ext   = 16'(cnt_reg);
  assign last_word = (cnt_ext + 16'd1) == len_reg;

  // Incoming byte lands in the lane selected by byte_idx_reg (little-endian).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? rx_data : word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = LEN_LO;
      LEN_LO: if (accept) state_next = LEN_HI;
      LEN_HI: if (accept) begin
        if (len_rx == 16'd0)     state_next = DONE;
        else if (len_rx > MAX_N) state_next = ERR;
        else                     state_next = DATA;
      end
      DATA:   if (accept && byte_idx_reg == 2'd3) state_next = WRITE;
`ifdef BOOT_LOADER_CKSUM_EN
      WRITE:  state_next = last_word ? CKSUM : DATA;
      CKSUM:  if (accept) state_next = (rx_data == sum_reg) ? DONE : ERR;
`else
      WRITE:  state_next = last_word ? DONE : DATA;
`endif
      DONE:   state_next = DONE;
      ERR:    if (start) state_next = LEN_LO;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    cpu_rst_n = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_reg)
      LEN_LO, LEN_HI, DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        busy   = 1'b1;
      end
`ifdef BOOT_LOADER_CKSUM_EN
      CKSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      DONE: begin
        cpu_rst_n = 1'b1;
        done      = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Address tracks the write count, so it reads 0 out of reset and in WRITE it is the word index.
  assign ram_addr    = cnt_reg[ADDR_W-1:0];
  assign ram_wr_data = word_reg;
  assign word_cnt    = cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_reg      <= '0;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      cnt_reg      <= '0;
`ifdef BOOT_LOADER_CKSUM_EN
      sum_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, ERR: if (start) begin
          cnt_reg      <= '0;
          byte_idx_reg <= '0;
`ifdef BOOT_LOADER_CKSUM_EN
          sum_reg      <= '0;
`endif
        end
        LEN_LO: if (accept) len_reg[7:0]  <= rx_data;
        LEN_HI: if (accept) len_reg[15:8] <= rx_data;
        DATA: if (accept) begin
          word_reg     <= word_next;
          byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef BOOT_LOADER_CKSUM_EN
          sum_reg      <= sum_reg + rx_data;
`endif
        end
        WRITE:   cnt_reg <= cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ram_loader.sv
// Directed bench for boot_ram_loader: image loads, zero/oversize length, stalls, mid-load reset.
module tb_boot_ram_loader;
  localparam int ADDR_W = 9;
  localparam int BOUND  = 40;
`ifdef BOOT_LOADER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, ram_en, ram_we, cpu_rst_n, busy, done, err;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wr_data;
  logic [ADDR_W:0]   word_cnt;

  int checks = 0;
  int passed = 0;
  logic [7:0] tb_sum;
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int rdy_in_write = 0;
  int acc_cnt = 0;

  boot_ram_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(512)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
    .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_wr_data);
      if (rx_ready) rdy_in_write++;
      $display("write addr=%0d data=%08h en=%0b", ram_addr, ram_wr_data, ram_en);
    end
  end

  always @(posedge clk) if (rx_valid && rx_ready) acc_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(n < BOUND), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      tb_sum = tb_sum + w[8*i +: 8];
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic finish_image();
`ifdef BOOT_LOADER_CKSUM_EN
    send_byte(tb_sum);
`endif
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < BOUND), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready), 32'd0);
    check({tag, "_ram_en"},    32'(ram_en), 32'd0);
    check({tag, "_ram_we"},    32'(ram_we), 32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wr_data, 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
    check({tag, "_word_cnt"},  32'(word_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'd0);

    // Two-word image, valid held high throughout
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rx_ready", 32'(rx_ready), 32'd1);
    tb_sum = 8'h00;
    send_len(16'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    finish_image();
    wait_end("t1_end_wait");
    check("t1_nwrites", 32'(wa_q.size()), 32'd2);
    check("t1_addr0", 32'(wa_q[0]), 32'd0);
    check("t1_data0", wd_q[0], 32'h0000_0013);
    check("t1_addr1", 32'(wa_q[1]), 32'd1);
    check("t1_data1", wd_q[1], 32'h0000_006F);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("t1_word_cnt", 32'(word_cnt), 32'd2);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_ready_in_write", 32'(rdy_in_write), 32'd0);
    pulse_start();
    tick(2);
    check("t1_start_in_done", 32'(done), 32'd1);
    check("t1_start_in_done_busy", 32'(busy), 32'd0);

    // Zero-length image
    do_reset();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_len(16'd0);
    rx_valid = 1'b0;
    begin
      int n = 0;
      while (!done && n < 3) begin
        @(negedge clk);
        n++;
      end
    end
    check("t2_done", 32'(done), 32'd1);
    check("t2_no_writes", 32'(wa_q.size()), 32'd0);
    check("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    // Oversize length, then recovery via start in ERR
    do_reset();
    pulse_start();
    send_len(16'd513);
    rx_valid = 1'b0;
    check("t3_err", 32'(err), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_no_writes", 32'(wa_q.size()), 32'd0);
    acc_cnt = 0;
    rdy_in_write = 0;
    pulse_start();
    check("t3_restart_busy", 32'(busy), 32'd1);
    check("t3_restart_err", 32'(err), 32'd0);
    tb_sum = 8'h00;
    send_len(16'd1);
    send_word(32'hDEAD_BEEF);
    finish_image();
    wait_end("t3_end_wait");
    check("t3_done2", 32'(done), 32'd1);
    check("t3_nwrites", 32'(wa_q.size()), 32'd1);
    check("t3_addr0", 32'(wa_q[0]), 32'd0);
    check("t3_data0", wd_q[0], 32'hDEAD_BEEF);
    check("t3_word_cnt", 32'(word_cnt), 32'd1);
    check("t3_bytes_once", 32'(acc_cnt), 32'(6 + CK));
    check("t3_ready_in_write", 32'(rdy_in_write), 32'd0);

    // Stalled bytes, start while busy, then reset after two of four words
    do_reset();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_len(16'd4);
    send_byte(8'h44);
    rx_valid = 1'b0;
    tick(3);
    send_byte(8'h33);
    rx_valid = 1'b0;
    pulse_start();
    tick(1);
    check("t4_start_while_busy", 32'(busy), 32'd1);
    send_byte(8'h22);
    send_byte(8'h11);
    tb_sum = 8'h00;
    send_word(32'h5566_7788);
    send_byte(8'h99);
    send_byte(8'hAA);
    rx_valid = 1'b0;
    check("t4_word_cnt", 32'(word_cnt), 32'd2);
    check("t4_nwrites", 32'(wa_q.size()), 32'd2);
    check("t4_data0_stalled", wd_q[0], 32'h1122_3344);
    check("t4_addr1", 32'(wa_q[1]), 32'd1);
    check("t4_data1", wd_q[1], 32'h5566_7788);
    rst_n = 1'b0;
    tick(1);
    check_reset_vals("t4_rst");
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("t4_no_more_writes", 32'(wa_q.size()), 32'd2);
    check("t4_idle_busy", 32'(busy), 32'd0);
    pulse_start();
    tb_sum = 8'h00;
    send_len(16'd1);
    send_word(32'hCAFE_F00D);
    finish_image();
    wait_end("t4_end_wait");
    check("t4_reload_nwrites", 32'(wa_q.size()), 32'd3);
    check("t4_reload_addr", 32'(wa_q[2]), 32'd0);
    check("t4_reload_data", wd_q[2], 32'hCAFE_F00D);
    check("t4_reload_done", 32'(done), 32'd1);

`ifdef BOOT_LOADER_CKSUM_EN
    // Wrong checksum byte (data sum is 0x82)
    do_reset();
    pulse_start();
    tb_sum = 8'h00;
    send_len(16'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    check("t5_model_sum", 32'(tb_sum), 32'h82);
    send_byte(8'h00);
    rx_valid = 1'b0;
    wait_end("t5_end_wait");
    check("t5_err", 32'(err), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
